// File: rtl/data_memory_ws_pkg.sv
// Shared definitions for the MIPS data memory: access size encodings,
// FSM state encoding and the default data segment base address.
package mips_mem_defs;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [31:0] DMEM_SEG_BEGIN_DEF = 32'h0000_1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Clear the low address bits a naturally aligned access of this size ignores.
  function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] lane);
    logic [1:0] res;
    res = lane;
    if (size == SZ_HALF) res = {lane[1], 1'b0};
    else if (size == SZ_WORD) res = 2'b00;
    return res;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory (little-endian lanes).
// Produces the byte enables and the replicated store word for writes, and
// the right-justified, optionally sign-extended load word for reads.
module dmem_lane_align
  import mips_mem_defs::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rext_o
);

  logic [31:0] shifted;

  // Lane selection and extension; the reserved size enables nothing.
  always_comb begin
    be_o    = 4'b0000;
    wword_o = 32'h0;
    rext_o  = 32'h0;
    shifted = rword_i >> {lane_i, 3'b000};
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << lane_i;
        wword_o = {4{wdata_i[7:0]}};
        rext_o  = {{24{sext_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
        rext_o  = {{16{sext_i & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
        rext_o  = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_ws.sv
// Word-organised data memory with byte/half/word access and wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses end
// with err instead of having their low address bits forced to zero.
//
// Handshake: the core raises req with all operands stable and holds them
// until done. A request is accepted only in IDLE; done is a one-cycle pulse
// (err qualifies it), and rdata holds the last load result until the next
// successful load. busy covers every cycle from accept to done.
module data_memory_ws
  import mips_mem_defs::*;
#(
  parameter logic [31:0] DATA_SEG_BEGIN = DMEM_SEG_BEGIN_DEF,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned WAIT_STATES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, sext_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      off;
  logic             in_range, misalign, acc_err, accept;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword, wword, rext;
  logic [3:0]       be;

  assign accept   = (state_q == ST_IDLE) && req;
  assign off      = addr_q - DATA_SEG_BEGIN;
  assign in_range = (addr_q >= DATA_SEG_BEGIN) && (off < WIN_BYTES);
  assign idx      = off[IDX_W+1:2];
  assign rword    = mem_q[idx];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((size_q == SZ_HALF) && off[0]) ||
                    ((size_q == SZ_WORD) && (off[1:0] != 2'b00));
  assign lane     = off[1:0];
`else
  assign misalign = 1'b0;
  assign lane     = force_align(size_q, off[1:0]);
`endif

  assign acc_err = !in_range || (size_q == SZ_RSVD) || misalign;

  dmem_lane_align u_align (
    .size_i  (size_q),
    .lane_i  (lane),
    .sext_i  (sext_q),
    .wdata_i (wdata_q),
    .rword_i (rword),
    .be_o    (be),
    .wword_o (wword),
    .rext_o  (rext)
  );

  // Next-state logic: WAIT lasts WAIT_STATES+1 cycles, then ACCESS, then RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else cnt_d = cnt_q - 4'd1;
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state, wait counter, latched operands and the response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        size_q  <= size;
        sext_q  <= sign_ext;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state_q == ST_ACCESS) begin
        err_q <= acc_err;
        if (!acc_err && !we_q) rdata_q <= rext;
      end else if (state_q == ST_RESP) begin
        err_q <= 1'b0;
      end
    end
  end

  // Byte-enabled store, committed on the edge that leaves ACCESS.
  always_ff @(posedge clk) begin
    if ((state_q == ST_ACCESS) && we_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_RESP);
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
